video_timing_gen: RTL and testbench



---
 rtl/video_pkg.sv | 31 +++
 rtl/clk_en_div.sv | 29 ++
 rtl/video_timing_gen.sv | 113 +++++++++++
 tb/tb_video_timing_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - raster timing descriptors shared by the video pipeline
package video_pkg;

   typedef struct packed {
      int   h_active;
      int   h_fp;
      int   h_sync;
      int   h_bp;
      int   v_active;
      int   v_fp;
      int   v_sync;
      int   v_bp;
      logic hs_pol;
      logic vs_pol;
   } timing_t;

   localparam timing_t TIMING_640X480_60 = '{
      h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
      hs_pol: 1'b0, vs_pol: 1'b0
   };

   function automatic int h_total(timing_t t);
      return t.h_active + t.h_fp + t.h_sync + t.h_bp;
   endfunction

   function automatic int v_total(timing_t t);
      return t.v_active + t.v_fp + t.v_sync + t.v_bp;
   endfunction

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - divides clk into a single-cycle rate tick every DIV clocks
module clk_en_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // tick is a decode of registered state so a consumer can act on the same edge
   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!en || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: pixel enable, syncs, display enable, coordinates
module video_timing_gen
   import video_pkg::*;
#(
   parameter int CE_DIV   = 4,
   parameter int H_ACTIVE = TIMING_640X480_60.h_active,
   parameter int H_FP     = TIMING_640X480_60.h_fp,
   parameter int H_SYNC   = TIMING_640X480_60.h_sync,
   parameter int H_BP     = TIMING_640X480_60.h_bp,
   parameter int V_ACTIVE = TIMING_640X480_60.v_active,
   parameter int V_FP     = TIMING_640X480_60.v_fp,
   parameter int V_SYNC   = TIMING_640X480_60.v_sync,
   parameter int V_BP     = TIMING_640X480_60.v_bp,
   parameter bit HS_POL   = TIMING_640X480_60.hs_pol,
   parameter bit VS_POL   = TIMING_640X480_60.vs_pol,
   parameter int X_W      = 10,
   parameter int Y_W      = 10
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           en,
   output logic           ce_pix,
   output logic           hsync,
   output logic           vsync,
   output logic           de,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           frame_start,
   output logic           frame_odd
);

   localparam timing_t T = '{
      h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
      v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP,
      hs_pol: HS_POL, vs_pol: VS_POL
   };
   localparam int H_TOTAL = h_total(T);
   localparam int V_TOTAL = v_total(T);
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = HS_BEG + H_SYNC;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = VS_BEG + V_SYNC;

   generate
      if (CE_DIV < 1 || H_TOTAL - 1 >= (1 << X_W) || V_TOTAL - 1 >= (1 << Y_W)) begin : g_bad_param
         $error("video_timing_gen: CE_DIV < 1 or X_W/Y_W too narrow for the raster totals");
      end
   endgenerate

   logic           tick;
   logic [X_W-1:0] h;
   logic [Y_W-1:0] v;
   logic           h_last, v_last, origin, in_de, in_hs, in_vs;

   clk_en_div #(.DIV(CE_DIV)) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .tick    (tick)
   );

   // comparisons run at 32 bits so a sync end equal to the total cannot wrap
   assign h_last = (int'(h) == H_TOTAL - 1);
   assign v_last = (int'(v) == V_TOTAL - 1);
   assign origin = (h == '0) && (v == '0);
   assign in_de  = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
   assign in_hs  = (int'(h) >= HS_BEG) && (int'(h) < HS_END);
   assign in_vs  = (int'(v) >= VS_BEG) && (int'(v) < VS_END);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h           <= '0;
         v           <= '0;
         ce_pix      <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
         frame_odd   <= 1'b0;
      end else if (!en) begin
         h           <= '0;
         v           <= '0;
         ce_pix      <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
      end else begin
         ce_pix      <= tick;
         frame_start <= 1'b0;
         if (tick) begin
            x           <= h;
            y           <= v;
            de          <= in_de;
            hsync       <= in_hs ? HS_POL : ~HS_POL;
            vsync       <= in_vs ? VS_POL : ~VS_POL;
            frame_start <= origin;
            if (origin) frame_odd <= ~frame_odd;
            if (h_last) begin
               h <= '0;
               v <= v_last ? '0 : v + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a small 8x6 raster
module tb_video_timing_gen;

   localparam int CE = 2;
   localparam int HA = 4, HFP = 1, HSW = 2, HBP = 1, HT = HA + HFP + HSW + HBP;
   localparam int VA = 3, VFP = 1, VSW = 1, VBP = 1, VT = VA + VFP + VSW + VBP;
   localparam int FT = HT * VT;

   logic clk = 1'b0, reset_n, en, en2;
   logic ce_pix, hsync, vsync, de, frame_start, frame_odd;
   logic [2:0] x, y;
   logic ce2, hs2, vs2, de2, fs2, fo2;
   logic [2:0] x2, y2;

   typedef struct {
      int cyc;
      int x;
      int y;
      bit de, hs, vs, fs, fo;
   } pix_t;

   pix_t sb[$];
   int   cyc = 0;
   int   n_chk = 0, n_fail = 0;
   bit   fo_m = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   video_timing_gen #(
      .CE_DIV(CE), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .X_W(3), .Y_W(3)
   ) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .ce_pix(ce_pix), .hsync(hsync),
      .vsync(vsync), .de(de), .x(x), .y(y), .frame_start(frame_start), .frame_odd(frame_odd)
   );

   video_timing_gen #(
      .CE_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .X_W(3), .Y_W(3)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .en(en2), .ce_pix(ce2), .hsync(hs2),
      .vsync(vs2), .de(de2), .x(x2), .y(y2), .frame_start(fs2), .frame_odd(fo2)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference: the k-th pixel after a restart sits at raster index k mod (HT*VT)
   function automatic pix_t model(int k, int start);
      pix_t e;
      int p;
      p = k % FT;
      e.cyc = start + CE * (k + 1);
      e.x   = p % HT;
      e.y   = p / HT;
      e.de  = (e.x < HA) && (e.y < VA);
      e.hs  = !((e.x >= HA + HFP) && (e.x < HA + HFP + HSW));
      e.vs  = !((e.y >= VA + VFP) && (e.y < VA + VFP + VSW));
      e.fs  = (p == 0);
      return e;
   endfunction

   task automatic run_seg(int n);
      pix_t e;
      int s;
      s = cyc;
      for (int k = 0; k < n / CE; k++) begin
         e = model(k, s);
         if (e.fs) fo_m = ~fo_m;
         e.fo = fo_m;
         sb.push_back(e);
      end
      reset_n = 1'b1;
      en = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", sb.size(), 0);
      sb.delete();
   endtask

   task automatic check_idle();
      chk("idle_ce_pix", ce_pix, 0);
      chk("idle_x", x, 0);
      chk("idle_y", y, 0);
      chk("idle_de", de, 0);
      chk("idle_hsync", hsync, 1);
      chk("idle_vsync", vsync, 1);
      chk("idle_frame_start", frame_start, 0);
      chk("idle_frame_odd", frame_odd, fo_m);
   endtask

   always @(negedge clk) begin
      pix_t e;
      if (ce_pix === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ce_pix at cycle %0d: got 1, expected 0", cyc);
         end else begin
            e = sb.pop_front();
            chk("ce_cycle", cyc, e.cyc);
            chk("x", x, e.x);
            chk("y", y, e.y);
            chk("de", de, e.de);
            chk("hsync", hsync, e.hs);
            chk("vsync", vsync, e.vs);
            chk("frame_start", frame_start, e.fs);
            chk("frame_odd", frame_odd, e.fo);
         end
      end
   end

   initial begin
      int p;
      reset_n = 1'b0;
      en = 1'b0;
      en2 = 1'b0;
      repeat (3) @(negedge clk);
      check_idle();
      chk("dut1_reset_ce", ce2, 0);
      chk("dut1_reset_fo", fo2, 0);

      // reset release with en high, one full frame plus a couple of pixels
      run_seg(CE * 50);
      en = 1'b0;
      repeat (2) @(negedge clk) check_idle();

      // stop at (5,2), idle 3 clks, restart from origin
      run_seg(CE * 22);
      chk("stop_x", x, 5);
      chk("stop_y", y, 2);
      en = 1'b0;
      repeat (3) @(negedge clk) check_idle();
      run_seg(CE * 50);
      en = 1'b0;

      // async reset between edges while hsync is active
      @(negedge clk);
      run_seg(CE * 6);
      chk("pre_reset_hsync", hsync, 0);
      #1 reset_n = 1'b0;
      #1;
      fo_m = 1'b0;
      check_idle();
      @(negedge clk);
      run_seg(CE * 50);
      en = 1'b0;

      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(1, 4)) @(negedge clk) check_idle();
         run_seg($urandom_range(2, 130));
         en = 1'b0;
      end

      // CE_DIV=1 instance: ce_pix stuck high, one frame every 48 clks
      @(negedge clk);
      en2 = 1'b1;
      for (int k = 0; k < 2 * FT; k++) begin
         @(negedge clk);
         p = k % FT;
         chk("div1_ce_pix", ce2, 1);
         chk("div1_x", x2, p % HT);
         chk("div1_y", y2, p / HT);
         chk("div1_de", de2, (p % HT < HA) && (p / HT < VA));
         chk("div1_hsync", hs2, !((p % HT >= HA + HFP) && (p % HT < HA + HFP + HSW)));
         chk("div1_vsync", vs2, !(p / HT == VA + VFP));
         chk("div1_frame_start", fs2, p == 0);
         chk("div1_frame_odd", fo2, (k / FT) % 2 == 0);
      end
      en2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("div1_idle_ce", ce2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
